controlador_acesso_memoria: RTL and testbench

- Initiator-side load/store sequencer between the processor datapath and the 16-bit-per-access data memory port.
- Accepts byte, halfword and word load/store requests.
- Splits each request into one or two halfword memory transactions; byte stores use read-modify-write.
- Performs sign/zero extension of load data and rejects misaligned or out-of-range addresses before touching memory.

---
 rtl/controlador_acesso_memoria.sv | 228 ++++++++++++++++++++++
 tb/tb_controlador_acesso_memoria.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_acesso_memoria.sv
// Load/store sequencer between the processor datapath and a 16-bit-per-access
// data memory port. Word accesses take two halfword transactions; byte stores
// are done as read-modify-write. Bad requests are answered without touching memory.
module controlador_acesso_memoria #(
  parameter int PROF_MEM = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valido,
  output logic        req_pronto,
  input  logic        req_escrita,
  input  logic [1:0]  req_tamanho,
  input  logic        req_sem_sinal,
  input  logic [31:0] req_endereco,
  input  logic [31:0] req_dado,
  output logic        resp_valido,
  output logic [31:0] resp_dado,
  output logic        resp_erro,
  output logic [31:0] endereco,
  output logic [31:0] valor_reg2,
  output logic        sinal_escrita,
  output logic        sinal_leitura,
  input  logic [31:0] dado_saida
);

  localparam logic [31:0] LIMITE = 32'(4 * PROF_MEM);

  typedef enum logic [2:0] {
    OCIOSO        = 3'd0,
    LE_BAIXO      = 3'd1,
    LE_ALTO       = 3'd2,
    RMW_LE        = 3'd3,
    ESCREVE_BAIXO = 3'd4,
    ESCREVE_ALTO  = 3'd5,
    RESPOSTA      = 3'd6
  } estado_t;

  function automatic logic [31:0] estende_meia(input logic [15:0] v, input logic sem_sinal);
    if (sem_sinal) begin
      estende_meia = {16'h0000, v};
    end else begin
      estende_meia = {{16{v[15]}}, v};
    end
  endfunction

  function automatic logic [31:0] estende_byte(input logic [7:0] v, input logic sem_sinal);
    if (sem_sinal) begin
      estende_byte = {24'h000000, v};
    end else begin
      estende_byte = {{24{v[7]}}, v};
    end
  endfunction

  estado_t     estado_q, estado_d;
  logic [1:0]  tamanho_q, tamanho_d;
  logic        sem_sinal_q, sem_sinal_d;
  logic        byte_sel_q, byte_sel_d;
  logic [7:0]  byte_q, byte_d;
  logic [15:0] dado_alto_q, dado_alto_d;
  logic [15:0] parcial_q, parcial_d;
  logic        req_pronto_q, req_pronto_d;
  logic        resp_valido_q, resp_valido_d;
  logic        resp_erro_q, resp_erro_d;
  logic [31:0] resp_dado_q, resp_dado_d;
  logic [31:0] endereco_q, endereco_d;
  logic [15:0] valor_q, valor_d;
  logic        sinal_escrita_q, sinal_escrita_d;
  logic        sinal_leitura_q, sinal_leitura_d;
  logic        fora_faixa_s;
  logic        req_invalido_s;
  logic        dado_saida_unused_s;

  // The memory returns the halfword already sign-extended; only [15:0] carries data.
  assign dado_saida_unused_s = ^dado_saida[31:16];

  // Request validation: alignment per size, address range, and the reserved size code.
  always_comb begin
    fora_faixa_s   = (req_endereco >= LIMITE);
    req_invalido_s = 1'b1;
    case (req_tamanho)
      2'b00:   req_invalido_s = fora_faixa_s;
      2'b01:   req_invalido_s = fora_faixa_s | req_endereco[0];
      2'b10:   req_invalido_s = fora_faixa_s | (req_endereco[1:0] != 2'b00);
      default: req_invalido_s = 1'b1;
    endcase
  end

  // Next-state and next-output logic; strobes and handshake follow the next state.
  always_comb begin
    estado_d    = estado_q;
    tamanho_d   = tamanho_q;
    sem_sinal_d = sem_sinal_q;
    byte_sel_d  = byte_sel_q;
    byte_d      = byte_q;
    dado_alto_d = dado_alto_q;
    parcial_d   = parcial_q;
    resp_erro_d = resp_erro_q;
    resp_dado_d = resp_dado_q;
    endereco_d  = endereco_q;
    valor_d     = valor_q;
    case (estado_q)
      OCIOSO: begin
        if (req_valido) begin
          tamanho_d   = req_tamanho;
          sem_sinal_d = req_sem_sinal;
          byte_sel_d  = req_endereco[0];
          byte_d      = req_dado[7:0];
          dado_alto_d = req_dado[31:16];
          if (req_invalido_s) begin
            estado_d    = RESPOSTA;
            resp_erro_d = 1'b1;
            resp_dado_d = 32'h0000_0000;
          end else begin
            resp_erro_d = 1'b0;
            endereco_d  = {req_endereco[31:1], 1'b0};
            if (!req_escrita) begin
              estado_d = LE_BAIXO;
            end else if (req_tamanho == 2'b00) begin
              estado_d = RMW_LE;
            end else begin
              estado_d = ESCREVE_BAIXO;
              valor_d  = req_dado[15:0];
            end
          end
        end else begin
          estado_d = OCIOSO;
        end
      end
      LE_BAIXO: begin
        case (tamanho_q)
          2'b00: begin
            resp_dado_d = estende_byte(byte_sel_q ? dado_saida[15:8] : dado_saida[7:0], sem_sinal_q);
            estado_d    = RESPOSTA;
          end
          2'b01: begin
            resp_dado_d = estende_meia(dado_saida[15:0], sem_sinal_q);
            estado_d    = RESPOSTA;
          end
          default: begin
            parcial_d  = dado_saida[15:0];
            endereco_d = endereco_q + 32'd2;
            estado_d   = LE_ALTO;
          end
        endcase
      end
      LE_ALTO: begin
        resp_dado_d = {dado_saida[15:0], parcial_q};
        estado_d    = RESPOSTA;
      end
      RMW_LE: begin
        // Replace only the addressed byte lane, keep the other one as read.
        valor_d  = byte_sel_q ? {byte_q, dado_saida[7:0]} : {dado_saida[15:8], byte_q};
        estado_d = ESCREVE_BAIXO;
      end
      ESCREVE_BAIXO: begin
        if (tamanho_q == 2'b10) begin
          endereco_d = endereco_q + 32'd2;
          valor_d    = dado_alto_q;
          estado_d   = ESCREVE_ALTO;
        end else begin
          resp_dado_d = 32'h0000_0000;
          estado_d    = RESPOSTA;
        end
      end
      ESCREVE_ALTO: begin
        resp_dado_d = 32'h0000_0000;
        estado_d    = RESPOSTA;
      end
      RESPOSTA: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
    req_pronto_d    = (estado_d == OCIOSO);
    resp_valido_d   = (estado_d == RESPOSTA);
    sinal_leitura_d = (estado_d == LE_BAIXO) || (estado_d == LE_ALTO) || (estado_d == RMW_LE);
    sinal_escrita_d = (estado_d == ESCREVE_BAIXO) || (estado_d == ESCREVE_ALTO);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado_q        <= OCIOSO;
      tamanho_q       <= 2'b00;
      sem_sinal_q     <= 1'b0;
      byte_sel_q      <= 1'b0;
      byte_q          <= 8'h00;
      dado_alto_q     <= 16'h0000;
      parcial_q       <= 16'h0000;
      req_pronto_q    <= 1'b1;
      resp_valido_q   <= 1'b0;
      resp_erro_q     <= 1'b0;
      resp_dado_q     <= 32'h0000_0000;
      endereco_q      <= 32'h0000_0000;
      valor_q         <= 16'h0000;
      sinal_escrita_q <= 1'b0;
      sinal_leitura_q <= 1'b0;
    end else begin
      estado_q        <= estado_d;
      tamanho_q       <= tamanho_d;
      sem_sinal_q     <= sem_sinal_d;
      byte_sel_q      <= byte_sel_d;
      byte_q          <= byte_d;
      dado_alto_q     <= dado_alto_d;
      parcial_q       <= parcial_d;
      req_pronto_q    <= req_pronto_d;
      resp_valido_q   <= resp_valido_d;
      resp_erro_q     <= resp_erro_d;
      resp_dado_q     <= resp_dado_d;
      endereco_q      <= endereco_d;
      valor_q         <= valor_d;
      sinal_escrita_q <= sinal_escrita_d;
      sinal_leitura_q <= sinal_leitura_d;
    end
  end

  assign req_pronto    = req_pronto_q;
  assign resp_valido   = resp_valido_q;
  assign resp_erro     = resp_erro_q;
  assign resp_dado     = resp_dado_q;
  assign endereco      = endereco_q;
  assign valor_reg2    = {16'h0000, valor_q};
  assign sinal_escrita = sinal_escrita_q;
  assign sinal_leitura = sinal_leitura_q;

endmodule

// File: tb/tb_controlador_acesso_memoria.sv
// Self-checking bench: a halfword memory model on the port, plus a byte-level
// reference of memory contents used to predict load results, latencies and strobe counts.
module tb_controlador_acesso_memoria;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valido;
  logic        req_pronto;
  logic        req_escrita;
  logic [1:0]  req_tamanho;
  logic        req_sem_sinal;
  logic [31:0] req_endereco;
  logic [31:0] req_dado;
  logic        resp_valido;
  logic [31:0] resp_dado;
  logic        resp_erro;
  logic [31:0] endereco;
  logic [31:0] valor_reg2;
  logic        sinal_escrita;
  logic        sinal_leitura;
  logic [31:0] dado_saida;

  int total = 0;
  int bad   = 0;
  int rd_total = 0;
  int wr_total = 0;
  logic [31:0] wlog_a[$];
  logic [31:0] wlog_v[$];
  logic [15:0] hw_mem [0:127];
  logic [15:0] hw_rd;
  logic [7:0]  ref_mem [0:255];

  controlador_acesso_memoria #(.PROF_MEM(64)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valido(req_valido), .req_pronto(req_pronto),
    .req_escrita(req_escrita), .req_tamanho(req_tamanho),
    .req_sem_sinal(req_sem_sinal), .req_endereco(req_endereco), .req_dado(req_dado),
    .resp_valido(resp_valido), .resp_dado(resp_dado), .resp_erro(resp_erro),
    .endereco(endereco), .valor_reg2(valor_reg2),
    .sinal_escrita(sinal_escrita), .sinal_leitura(sinal_leitura),
    .dado_saida(dado_saida)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    total++;
    if (obs !== esp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, esp);
    end
  endtask

  // Memory read port: selected halfword, sign-extended.
  always_comb begin
    hw_rd = 16'h0000;
    if (endereco < 32'd256) hw_rd = hw_mem[endereco[7:1]];
    dado_saida = {{16{hw_rd[15]}}, hw_rd};
  end

  // Memory writes on negedge, plus strobe bookkeeping.
  always @(negedge clock) begin
    if (sinal_leitura || sinal_escrita) check_eq("strobe_unico", 32'(sinal_leitura & sinal_escrita), 32'd0);
    if (sinal_leitura) rd_total <= rd_total + 1;
    if (sinal_escrita) begin
      check_eq("v2_alto", {16'h0000, valor_reg2[31:16]}, 32'd0);
      wr_total <= wr_total + 1;
      wlog_a.push_back(endereco);
      wlog_v.push_back(valor_reg2);
      if (endereco < 32'd256) hw_mem[endereco[7:1]] <= valor_reg2[15:0];
    end
  end

  function automatic logic [31:0] modelo_leitura(input logic [1:0] tam, input logic ss, input logic [31:0] a);
    logic [7:0] i;
    logic [31:0] w;
    i = a[7:0];
    w = {ref_mem[8'(i + 8'd3)], ref_mem[8'(i + 8'd2)], ref_mem[8'(i + 8'd1)], ref_mem[i]};
    if (tam == 2'd0) return ss ? {24'h0, w[7:0]} : {{24{w[7]}}, w[7:0]};
    if (tam == 2'd1) return ss ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
    return w;
  endfunction

  task automatic embaralha();
    req_escrita   = 1'($urandom_range(0, 1));
    req_tamanho   = 2'($urandom_range(0, 3));
    req_sem_sinal = 1'($urandom_range(0, 1));
    req_endereco  = 32'($urandom_range(0, 255));
    req_dado      = $urandom;
  endtask

  task automatic do_req(input logic wr, input logic [1:0] tam, input logic ss,
                        input logic [31:0] a, input logic [31:0] d, input bit hold);
    int wcnt, lat, rd0, wr0, e_lat, e_rd, e_wr;
    logic err;
    logic [31:0] e_d;
    err = (tam == 2'd3) || (tam == 2'd2 && a[1:0] != 2'b00) || (tam == 2'd1 && a[0]) || (a >= 32'd256);
    e_d = 32'd0;
    if (err) begin
      e_lat = 1; e_rd = 0; e_wr = 0;
    end else if (wr) begin
      if (tam == 2'd0)      begin e_lat = 3; e_rd = 1; e_wr = 1; end
      else if (tam == 2'd1) begin e_lat = 2; e_rd = 0; e_wr = 1; end
      else                  begin e_lat = 3; e_rd = 0; e_wr = 2; end
    end else begin
      e_d   = modelo_leitura(tam, ss, a);
      e_lat = (tam == 2'd2) ? 3 : 2;
      e_rd  = (tam == 2'd2) ? 2 : 1;
      e_wr  = 0;
    end
    @(negedge clock);
    req_valido = 1'b1; req_escrita = wr; req_tamanho = tam;
    req_sem_sinal = ss; req_endereco = a; req_dado = d;
    wcnt = 0;
    while (!req_pronto && wcnt < 8) begin
      @(negedge clock);
      wcnt++;
    end
    check_eq("espera_pronto", 32'(wcnt), 32'd0);
    rd0 = rd_total; wr0 = wr_total;
    @(posedge clock); #1;
    req_valido = hold;
    embaralha();
    lat = 1;
    while (!resp_valido && lat < 12) begin
      @(posedge clock); #1;
      lat++;
      embaralha();
    end
    check_eq("latencia", 32'(lat), 32'(e_lat));
    check_eq("erro", {31'd0, resp_erro}, {31'd0, err});
    check_eq("dado", resp_dado, e_d);
    check_eq("leituras", 32'(rd_total - rd0), 32'(e_rd));
    check_eq("escritas", 32'(wr_total - wr0), 32'(e_wr));
    if (!err && wr) begin
      ref_mem[a[7:0]] = d[7:0];
      if (tam != 2'd0) ref_mem[8'(a[7:0] + 8'd1)] = d[15:8];
      if (tam == 2'd2) begin
        ref_mem[8'(a[7:0] + 8'd2)] = d[23:16];
        ref_mem[8'(a[7:0] + 8'd3)] = d[31:24];
      end
    end
    @(posedge clock); #1;
    check_eq("pulso_unico", {31'd0, resp_valido}, 32'd0);
    check_eq("dado_retido", resp_dado, e_d);
    if (!hold) req_valido = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ws;
    bit ok;
    reset_n = 1'b0; req_valido = 1'b0; req_escrita = 1'b0; req_tamanho = 2'b00;
    req_sem_sinal = 1'b0; req_endereco = 32'd0; req_dado = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_pronto", {31'd0, req_pronto}, 32'd1);
    check_eq("rst_resp_valido", {31'd0, resp_valido}, 32'd0);
    check_eq("rst_resp_erro", {31'd0, resp_erro}, 32'd0);
    check_eq("rst_resp_dado", resp_dado, 32'd0);
    check_eq("rst_endereco", endereco, 32'd0);
    check_eq("rst_valor", valor_reg2, 32'd0);
    check_eq("rst_escrita", {31'd0, sinal_escrita}, 32'd0);
    check_eq("rst_leitura", {31'd0, sinal_leitura}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Fill the whole memory through the block with word stores.
    for (int i = 0; i < 64; i++) do_req(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 1'b0);

    // Halfword store/load, signed and unsigned.
    do_req(1'b1, 2'd1, 1'b0, 32'h10, 32'h0000_BEEF, 1'b0);
    do_req(1'b0, 2'd1, 1'b0, 32'h10, 32'd0, 1'b0);
    check_eq("hw_signed", resp_dado, 32'hFFFF_BEEF);
    do_req(1'b0, 2'd1, 1'b1, 32'h10, 32'd0, 1'b0);
    check_eq("hw_unsigned", resp_dado, 32'h0000_BEEF);

    // Word store: two halfword writes in order.
    ws = wlog_a.size();
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h1234_5678, 1'b0);
    check_eq("w_end0", wlog_a[ws], 32'h20);
    check_eq("w_val0", wlog_v[ws], 32'h5678);
    check_eq("w_end1", wlog_a[ws + 1], 32'h22);
    check_eq("w_val1", wlog_v[ws + 1], 32'h1234);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 1'b0);
    check_eq("w_load", resp_dado, 32'h1234_5678);

    // Byte store as read-modify-write, then byte loads.
    do_req(1'b1, 2'd1, 1'b0, 32'h30, 32'h0000_AABB, 1'b0);
    ws = wlog_a.size();
    do_req(1'b1, 2'd0, 1'b0, 32'h31, 32'h0000_005C, 1'b0);
    check_eq("rmw_end", wlog_a[ws], 32'h30);
    check_eq("rmw_val", wlog_v[ws], 32'h5CBB);
    do_req(1'b0, 2'd0, 1'b0, 32'h30, 32'd0, 1'b0);
    check_eq("b_signed", resp_dado, 32'hFFFF_FFBB);
    do_req(1'b0, 2'd0, 1'b1, 32'h31, 32'd0, 1'b0);
    check_eq("b_unsigned", resp_dado, 32'h0000_005C);

    // Rejected requests.
    do_req(1'b0, 2'd2, 1'b0, 32'h22, 32'd0, 1'b0);
    do_req(1'b1, 2'd1, 1'b0, 32'h13, 32'h1111, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 1'b0);
    do_req(1'b0, 2'd3, 1'b0, 32'h40, 32'd0, 1'b0);

    // Reset during the high-half write of a word store.
    @(negedge clock);
    req_valido = 1'b1; req_escrita = 1'b1; req_tamanho = 2'd2;
    req_endereco = 32'h40; req_dado = 32'h1111_2222;
    @(posedge clock); #1;
    req_valido = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_eq("alto_escrita", {31'd0, sinal_escrita}, 32'd1);
    check_eq("alto_endereco", endereco, 32'h42);
    check_eq("alto_valor", valor_reg2, 32'h1111);
    reset_n = 1'b0;
    @(posedge clock); #1;
    check_eq("rr_escrita", {31'd0, sinal_escrita}, 32'd0);
    check_eq("rr_leitura", {31'd0, sinal_leitura}, 32'd0);
    check_eq("rr_resp_valido", {31'd0, resp_valido}, 32'd0);
    check_eq("rr_pronto", {31'd0, req_pronto}, 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      if (resp_valido || !req_pronto) ok = 1'b0;
    end
    check_eq("rr_quieto", {31'd0, ok}, 32'd1);
    do_req(1'b1, 2'd2, 1'b0, 32'h40, $urandom, 1'b0);

    // Request held valid with changing fields while busy.
    do_req(1'b1, 2'd2, 1'b0, 32'h50, 32'hCAFE_F00D, 1'b1);
    do_req(1'b0, 2'd2, 1'b0, 32'h50, 32'd0, 1'b0);
    check_eq("hold_load", resp_dado, 32'hCAFE_F00D);

    // Randomized traffic checked against the byte-level reference.
    for (int n = 0; n < 300; n++) begin
      int sel;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = $urandom;
      else if (sel == 1) a = 32'(256 + $urandom_range(0, 15));
      else               a = 32'($urandom_range(0, 255));
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, ($urandom_range(0, 7) == 0));
    end
    req_valido = 1'b0;
    repeat (2) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
